multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32-style datapath sharing one memory port.
// state  | meaning
// FETCH  | read instruction via PC, write IR on ack
// DECODE | classify opcode, latch class or trap as illegal
// EXEC   | ALU operation into ALUOut; branches finish here
// MEM    | load/store via ALUOut address
// WB     | register write-back and PC update
// HALT   | fault stop, only reset leaves
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_opcode,
  input  logic        i_br_taken,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_sel,
  output logic        o_ir_we,
  output logic        o_aluout_we,
  output logic        o_pc_we,
  output logic        o_rd_we,
  output logic [1:0]  o_pc_sel,
  output logic [1:0]  o_wb_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic        o_retire,
  output logic [31:0] o_instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] C_RTYPE  = 4'd0;
  localparam logic [3:0] C_ITYPE  = 4'd1;
  localparam logic [3:0] C_IITYPE = 4'd2;
  localparam logic [3:0] C_ILTYPE = 4'd3;
  localparam logic [3:0] C_IJTYPE = 4'd4;
  localparam logic [3:0] C_STYPE  = 4'd5;
  localparam logic [3:0] C_BTYPE  = 4'd6;
  localparam logic [3:0] C_U1TYPE = 4'd7;
  localparam logic [3:0] C_U2TYPE = 4'd8;
  localparam logic [3:0] C_BAD    = 4'd15;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    class_q, class_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   instret_q, instret_d;

  function automatic logic [3:0] decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_RTYPE;
      7'b0010011: decode_class = C_ITYPE;
      7'b1100111: decode_class = C_IITYPE;
      7'b0000011: decode_class = C_ILTYPE;
      7'b1101111: decode_class = C_IJTYPE;
      7'b0100011: decode_class = C_STYPE;
      7'b1100011: decode_class = C_BTYPE;
      7'b0110111: decode_class = C_U1TYPE;
      7'b0010111: decode_class = C_U2TYPE;
      default:    decode_class = C_BAD;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (i_mem_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        class_d = decode_class(i_opcode);
        if (class_d == C_BAD) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (class_q == C_ILTYPE || class_q == C_STYPE) state_d = S_MEM;
        else if (class_q == C_BTYPE)                    state_d = S_FETCH;
        else                                            state_d = S_WB;
      end
      S_MEM: begin
        // ack beats timeout when both land in the same cycle
        if (i_mem_ack) begin
          state_d = (class_q == C_STYPE) ? S_FETCH : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_sel   = 1'b0;
    o_ir_we     = 1'b0;
    o_aluout_we = 1'b0;
    o_pc_we     = 1'b0;
    o_rd_we     = 1'b0;
    o_pc_sel    = 2'd0;
    o_wb_sel    = 2'd0;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_retire    = 1'b0;
    if (!i_rst) begin
      case (state_q)
        S_FETCH: begin
          o_mem_req = 1'b1;
          o_ir_we   = i_mem_ack;
        end
        S_EXEC: begin
          o_aluout_we = 1'b1;
          case (class_q)
            C_RTYPE: begin
              o_alu_a_sel = 1'b0;
              o_alu_b_sel = 1'b0;
            end
            C_BTYPE, C_IJTYPE, C_U2TYPE: begin
              o_alu_a_sel = 1'b1;
              o_alu_b_sel = 1'b1;
            end
            default: begin
              o_alu_a_sel = 1'b0;
              o_alu_b_sel = 1'b1;
            end
          endcase
          if (class_q == C_BTYPE) begin
            o_pc_we  = 1'b1;
            o_pc_sel = {1'b0, i_br_taken};
            o_retire = 1'b1;
          end
        end
        S_MEM: begin
          o_mem_req = 1'b1;
          o_mem_sel = 1'b1;
          o_mem_we  = (class_q == C_STYPE);
          if (i_mem_ack && class_q == C_STYPE) begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
          end
        end
        S_WB: begin
          o_rd_we  = 1'b1;
          o_pc_we  = 1'b1;
          o_retire = 1'b1;
          case (class_q)
            C_ILTYPE:           o_wb_sel = 2'd1;
            C_IJTYPE, C_IITYPE: o_wb_sel = 2'd2;
            C_U1TYPE:           o_wb_sel = 2'd3;
            default:            o_wb_sel = 2'd0;
          endcase
          case (class_q)
            C_IJTYPE: o_pc_sel = 2'd2;
            C_IITYPE: o_pc_sel = 2'd3;
            default:  o_pc_sel = 2'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign instret_d = o_retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      class_q   <= C_RTYPE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign o_illegal = illegal_q;
  assign o_bus_err = bus_err_q;
  assign o_instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: runs single instructions against a
// memory responder with programmable ack delay and checks strobes per phase.
module tb_multicycle_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [6:0]  i_opcode = 7'd0;
  logic        i_br_taken = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic        o_mem_req, o_mem_we, o_mem_sel, o_ir_we, o_aluout_we, o_pc_we, o_rd_we;
  logic [1:0]  o_pc_sel, o_wb_sel;
  logic        o_alu_a_sel, o_alu_b_sel, o_illegal, o_bus_err, o_retire;
  logic [31:0] o_instret;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_br_taken(i_br_taken),
    .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_sel(o_mem_sel), .o_ir_we(o_ir_we), .o_aluout_we(o_aluout_we),
    .o_pc_we(o_pc_we), .o_rd_we(o_rd_we), .o_pc_sel(o_pc_sel), .o_wb_sel(o_wb_sel),
    .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel), .o_illegal(o_illegal),
    .o_bus_err(o_bus_err), .o_retire(o_retire), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;

  int n_cyc, n_ret, n_rdwe, n_act, n_req_f, n_req_m;
  logic [1:0] wb_sel_s, wb_pc_s, pc_sel_s;
  logic mem_we_s, alu_a_s, alu_b_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // fdly/mdly: req cycles before ack in fetch/mem phase; -1 = never ack
  task automatic exec_instr(input logic [6:0] op, input int fdly, input int mdly,
                            input logic br, input int limit);
    int k;
    int dly;
    k = 0;
    n_cyc = 0; n_ret = 0; n_rdwe = 0; n_act = 0; n_req_f = 0; n_req_m = 0;
    wb_sel_s = 2'bx; wb_pc_s = 2'bx; pc_sel_s = 2'bx;
    mem_we_s = 1'bx; alu_a_s = 1'bx; alu_b_s = 1'bx;
    for (int c = 0; c < limit; c++) begin
      @(negedge i_clk);
      i_opcode   = op;
      i_br_taken = br;
      if (o_mem_req) begin
        dly = o_mem_sel ? mdly : fdly;
        i_mem_ack = (k == dly);
        if (o_mem_sel) begin
          n_req_m++;
          mem_we_s = o_mem_we;
        end else begin
          n_req_f++;
        end
        k = i_mem_ack ? 0 : k + 1;
      end else begin
        i_mem_ack = 1'b0;
      end
      #1;
      n_cyc++;
      if (o_rd_we) begin
        n_rdwe++;
        wb_sel_s = o_wb_sel;
        wb_pc_s  = o_pc_sel;
      end
      if (o_pc_we) pc_sel_s = o_pc_sel;
      if (o_aluout_we) begin
        alu_a_s = o_alu_a_sel;
        alu_b_s = o_alu_b_sel;
      end
      if (o_ir_we | o_aluout_we | o_pc_we | o_rd_we | o_retire | o_mem_req) n_act++;
      if (o_retire) begin
        n_ret++;
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_mem_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_strobes", {o_mem_req, o_ir_we, o_aluout_we, o_pc_we, o_rd_we, o_retire}, 0);
    chk("rst_flags", {o_illegal, o_bus_err}, 0);
    chk("rst_instret", o_instret, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    chk("refetch", {o_mem_req, o_mem_sel, o_mem_we}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ADDI, ack in the first fetch cycle
    exec_instr(OP_ADDI, 0, 0, 1'b0, 20);
    chk("addi_cyc", n_cyc, 4);
    chk("addi_ret", n_ret, 1);
    chk("addi_rdwe", n_rdwe, 1);
    chk("addi_wbsel", wb_sel_s, 0);
    chk("addi_pcsel", wb_pc_s, 0);
    chk("addi_alu", {alu_a_s, alu_b_s}, 2'b01);
    chk("addi_instret", o_instret, 1);

    // LW, data ack three cycles after the request
    exec_instr(OP_LW, 0, 3, 1'b0, 30);
    chk("lw_memreq", n_req_m, 4);
    chk("lw_memwe", mem_we_s, 0);
    chk("lw_wbsel", wb_sel_s, 1);
    chk("lw_cyc", n_cyc, 8);
    chk("lw_instret", o_instret, 2);

    exec_instr(OP_BEQ, 1, 0, 1'b1, 20);
    chk("beqt_cyc", n_cyc, 4);
    chk("beqt_rdwe", n_rdwe, 0);
    chk("beqt_pcsel", pc_sel_s, 1);
    chk("beqt_ret", n_ret, 1);
    exec_instr(OP_BEQ, 1, 0, 1'b0, 20);
    chk("beqn_cyc", n_cyc, 4);
    chk("beqn_rdwe", n_rdwe, 0);
    chk("beqn_pcsel", pc_sel_s, 0);
    chk("beqn_alu", {alu_a_s, alu_b_s}, 2'b11);
    chk("beq_instret", o_instret, 4);

    exec_instr(OP_SW, 0, 0, 1'b0, 20);
    chk("sw_memwe", mem_we_s, 1);
    chk("sw_rdwe", n_rdwe, 0);
    chk("sw_cyc", n_cyc, 4);
    chk("sw_pcsel", pc_sel_s, 0);

    exec_instr(OP_R, 0, 0, 1'b0, 20);
    chk("r_alu", {alu_a_s, alu_b_s}, 2'b00);
    exec_instr(OP_JAL, 0, 0, 1'b0, 20);
    chk("jal_sel", {wb_sel_s, wb_pc_s}, {2'd2, 2'd2});
    chk("jal_alu", {alu_a_s, alu_b_s}, 2'b11);
    exec_instr(OP_LUI, 0, 0, 1'b0, 20);
    chk("lui_wbsel", wb_sel_s, 3);
    exec_instr(OP_AUI, 0, 0, 1'b0, 20);
    chk("auipc_sel", {wb_sel_s, wb_pc_s, alu_a_s, alu_b_s}, {2'd0, 2'd0, 2'b11});
    chk("instret_9", o_instret, 9);

    // preset the retire counter so the next retire wraps it
    @(negedge i_clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge i_clk);
    release dut.instret_q;
    #1;
    chk("preset", o_instret, 32'hFFFF_FFFF);
    exec_instr(OP_JALR, 0, 0, 1'b0, 20);
    chk("jalr_pcsel", wb_pc_s, 3);
    chk("jalr_wbsel", wb_sel_s, 2);
    chk("instret_wrap", o_instret, 0);

    // ack on the 16th fetch cycle still succeeds
    exec_instr(OP_ADDI, 15, 0, 1'b0, 40);
    chk("late_ack_ret", n_ret, 1);
    chk("late_ack_cyc", n_cyc, 19);
    chk("late_ack_err", o_bus_err, 0);

    exec_instr(OP_ADDI, -1, 0, 1'b0, 30);
    chk("to_req", n_req_f, 16);
    chk("to_ret", n_ret, 0);
    chk("to_err", o_bus_err, 1);
    exec_instr(OP_ADDI, 0, 0, 1'b0, 10);
    chk("to_halt_quiet", n_act, 0);

    do_reset();
    exec_instr(7'b0000000, 0, 0, 1'b0, 12);
    chk("ill_flag", o_illegal, 1);
    chk("ill_ret", n_ret, 0);
    chk("ill_act", n_act, 1);
    chk("ill_buserr", o_bus_err, 0);

    do_reset();
    exec_instr(OP_ADDI, 0, 0, 1'b0, 20);
    chk("post_ill_ret", n_ret, 1);
    chk("post_ill_instret", o_instret, 1);

    // reset while a load is stalled in MEM
    exec_instr(OP_LW, 0, -1, 1'b0, 5);
    chk("abort_memreq", n_req_m, 2);
    chk("abort_rdwe", n_rdwe, 0);
    do_reset();
    exec_instr(OP_ADDI, 0, 0, 1'b0, 20);
    chk("post_abort_ret", n_ret, 1);
    chk("post_abort_instret", o_instret, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
